// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between an issuing stage and alu_exec_unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             invalid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alu_op, funct, a, b, shamt,
    input  result, zero, busy, done, invalid, hi, lo
  );

  modport slave (
    input  start, alu_op, funct, a, b, shamt,
    output result, zero, busy, done, invalid, hi, lo
  );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS-style execute unit: single-cycle ALU ops plus iterative
// shift-add multiply and restoring divide feeding HI/LO.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            rst,
  alu_exec_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d, adz_q, adz_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, done_q, done_d, invalid_q, invalid_d;

  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   alu_res, a_mag, b_mag;
  logic               alu_inv, is_mul, is_div, is_signed;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0]   step_acc, step_mq, q_s, r_s;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign sh = bus.shamt;

  always_comb begin
    alu_res   = '0;
    alu_inv   = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (bus.alu_op)
      2'b00: alu_res = bus.a + bus.b;
      2'b01: alu_res = bus.a - bus.b;
      2'b11: alu_res = bus.a | bus.b;
      default: begin
        case (bus.funct)
          6'b100000, 6'b100001: alu_res = bus.a + bus.b;
          6'b100010, 6'b100011: alu_res = bus.a - bus.b;
          6'b100100: alu_res = bus.a & bus.b;
          6'b100101: alu_res = bus.a | bus.b;
          6'b100110: alu_res = bus.a ^ bus.b;
          6'b100111: alu_res = ~(bus.a | bus.b);
          6'b101010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
          6'b101011: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
          6'b000000: alu_res = bus.b << sh;
          6'b000010: alu_res = bus.b >> sh;
          6'b000011: alu_res = $signed(bus.b) >>> sh;
          6'b010000: alu_res = hi_q;
          6'b010010: alu_res = lo_q;
          6'b011000: begin is_mul = 1'b1; is_signed = 1'b1; end
          6'b011001: is_mul = 1'b1;
          6'b011010: begin is_div = 1'b1; is_signed = 1'b1; end
          6'b011011: is_div = 1'b1;
          default:   alu_inv = 1'b1;
        endcase
      end
    endcase
  end

  // Iterate on magnitudes; signs are reapplied once on the final step.
  assign a_mag = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q, mq_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (state_q == MUL) begin
      step_acc = mul_sum[WIDTH:1];
      step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end else begin
      step_acc = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_mq  = {mq_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end
    prod   = {step_acc, step_mq};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -step_mq : step_mq;
    r_s    = rneg_q ? -step_acc : step_acc;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opnd_d    = opnd_q;
    adz_d     = adz_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    result_d  = result_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    invalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_mul || is_div) begin
            state_d = is_mul ? MUL : DIV;
            cnt_d   = CW'(WIDTH);
            acc_d   = '0;
            mq_d    = is_mul ? b_mag : a_mag;
            opnd_d  = is_mul ? a_mag : b_mag;
            neg_d   = is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rneg_d  = is_signed & bus.a[WIDTH-1];
            dz_d    = (bus.b == '0);
            adz_d   = bus.a;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            done_d    = 1'b1;
            invalid_d = alu_inv;
          end
        end
      end
      MUL, DIV: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (state_q == MUL) begin
            {hi_d, lo_d} = prod_s;
          end else if (dz_q) begin
            lo_d = '1;
            hi_d = adz_q;
          end else begin
            lo_d = q_s;
            hi_d = r_s;
          end
          result_d = lo_d;
          zero_d   = (lo_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      adz_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opnd_q    <= opnd_d;
      adz_q     <= adz_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.invalid = invalid_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus();
  alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int failures = 0;

  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_zero = 1'b1, m_done = 1'b0, m_inv = 1'b0;
  int          m_rem = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic void ref_op(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                 input logic [31:0] hi_in, input logic [31:0] lo_in,
                                 output bit multi, output logic [31:0] res, output bit inv,
                                 output logic [31:0] nhi, output logic [31:0] nlo);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    multi = 0; res = '0; inv = 0; nhi = hi_in; nlo = lo_in;
    sa = $signed(a); sb = $signed(b);
    case (op)
      2'b00: res = a + b;
      2'b01: res = a - b;
      2'b11: res = a | b;
      default: case (f)
        6'h20, 6'h21: res = a + b;
        6'h22, 6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: res = (a < b) ? 32'd1 : 32'd0;
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: res = sb >>> sh;
        6'h10: res = hi_in;
        6'h12: res = lo_in;
        6'h18: begin multi = 1; sp = longint'(sa) * longint'(sb); {nhi, nlo} = sp; end
        6'h19: begin multi = 1; up = {32'd0, a} * {32'd0, b}; {nhi, nlo} = up; end
        6'h1A: begin
          multi = 1;
          if (b == 0) begin nlo = '1; nhi = a; end
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin nlo = a; nhi = '0; end
          else begin nlo = sa / sb; nhi = sa % sb; end
        end
        6'h1B: begin
          multi = 1;
          if (b == 0) begin nlo = '1; nhi = a; end
          else begin nlo = a / b; nhi = a % b; end
        end
        default: inv = 1;
      endcase
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    bit multi, inv;
    logic [31:0] res, nhi, nlo;
    if (rst) begin
      m_res = '0; m_hi = '0; m_lo = '0; m_zero = 1'b1;
      m_done = 1'b0; m_inv = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0; m_inv = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_res = p_lo; m_zero = (p_lo == 0); m_done = 1'b1;
        end
      end else if (bus.start) begin
        ref_op(bus.alu_op, bus.funct, bus.a, bus.b, bus.shamt, m_hi, m_lo, multi, res, inv, nhi, nlo);
        if (multi) begin
          p_hi = nhi; p_lo = nlo; m_rem = W;
        end else begin
          m_res = res; m_zero = (res == 0); m_done = 1'b1; m_inv = inv;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", bus.busy, m_rem > 0);
    chk("done", bus.done, m_done);
    chk("invalid", bus.invalid, m_inv);
    chk("result", bus.result, m_res);
    chk("zero", bus.zero, m_zero);
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    bus.alu_op = op; bus.funct = f; bus.a = a; bus.b = b; bus.shamt = sh;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (!bus.done && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_timeout", bus.done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [5:0]  fl [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                           6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h1A, 6'h1B};
  logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int cyc;
    bus.start = 1'b0; bus.alu_op = '0; bus.funct = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_zero", bus.zero, 1'b1);
    chk("reset_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    issue(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1, 5'd0);
    wait_done(2, cyc);
    chk("slt_lat", cyc, 0);
    chk("slt", bus.result, 32'h1);
    issue(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'h1, 5'd0);
    chk("sltu", bus.result, 32'h0);
    chk("sltu_zero", bus.zero, 1'b1);
    issue(2'b10, 6'h03, 32'h0, 32'h8000_0000, 5'd4);
    chk("sra", bus.result, 32'hF800_0000);

    issue(2'b10, 6'h18, 32'hFFFF_FFFE, 32'h3, 5'd0);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      bus.start = (cyc < 5);
      bus.alu_op = 2'b00; bus.a = 32'h55; bus.b = 32'h11;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("mult_latency", cyc, 32);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    chk("mult_result", bus.result, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("mult_single_done", bus.done, 1'b0);

    issue(2'b10, 6'h1A, 32'hFFFF_FFF9, 32'h2, 5'd0);
    wait_done(40, cyc);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    issue(2'b10, 6'h1B, 32'h7, 32'h0, 5'd0);
    wait_done(40, cyc);
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus.hi, 32'h7);
    chk("divu0_inv", bus.invalid, 1'b0);
    issue(2'b10, 6'h10, 32'h0, 32'h0, 5'd0);
    chk("mfhi_b2b", bus.result, 32'h7);
    issue(2'b10, 6'h3F, 32'h1, 32'h1, 5'd0);
    chk("inv_pulse", bus.invalid, 1'b1);
    chk("inv_result", bus.result, 32'h0);
    chk("inv_hi", bus.hi, 32'h7);
    issue(2'b11, 6'h00, 32'hF0, 32'h0F, 5'd0);
    chk("or_op", bus.result, 32'hFF);
    chk("or_inv", bus.invalid, 1'b0);
    issue(2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    wait_done(40, cyc);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0);

    issue(2'b10, 6'h19, 32'h5, 32'h7, 5'd0);
    repeat (9) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b10, 6'h12, 32'h0, 32'h0, 5'd0);
    chk("mflo_after_rst", bus.result, 32'h0);
    chk("mflo_after_rst_done", bus.done, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      bus.start  = ($urandom_range(0, 2) == 0);
      bus.alu_op = 2'($urandom_range(0, 3));
      bus.funct  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fl[$urandom_range(0, 17)];
      bus.a      = pick();
      bus.b      = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      bus.shamt  = 5'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
